// File: rtl/i2s_rx.sv
// I2S receiver: deserialises sdata into left/right sample pairs offered on a valid/ready interface.
// Optional saturating drop counter (overrun_cnt / overrun_clr) is built when I2S_RX_OVERRUN_CNT_EN is defined.
module i2s_rx #(
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  sdata,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef I2S_RX_OVERRUN_CNT_EN
  input  logic                  overrun_clr,
  output logic [7:0]            overrun_cnt,
`endif
  output logic                  overrun
);

  generate
    if (DATA_WIDTH < 8 || DATA_WIDTH > 31) begin : g_bad_width
      $error("i2s_rx: DATA_WIDTH must be within 8..31");
    end
  endgenerate

  typedef enum logic {SYNC, RUN} state_e;

  localparam logic [4:0] IDX_LAST = 5'(DATA_WIDTH);

  logic                  sdata_d1_q, sdata_d2_q;
  logic                  bclk_d1_q, bclk_d2_q, bclk_d3_q;
  logic                  lrclk_d1_q, lrclk_d2_q;
  logic                  rise;
  logic                  lr_prev_q, lr_prev_d;
  logic [4:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [DATA_WIDTH-1:0] word;
  logic                  left_ok_q, left_ok_d;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_done;

  always_comb begin
    rise        = bclk_d2_q & ~bclk_d3_q;
    word        = {sr_q[DATA_WIDTH-2:0], sdata_d2_q};
    lr_prev_d   = lr_prev_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_done  = 1'b0;

    if (rise) begin
      lr_prev_d = lrclk_d2_q;
      if (lrclk_d2_q != lr_prev_q) begin
        idx_d = '0;
      end else if (idx_q != 5'd31) begin
        idx_d = idx_q + 5'd1;
      end
      // Slot 0 is the I2S delay bit; bits past the word width are truncated.
      if (idx_d >= 5'd1 && idx_d <= IDX_LAST) begin
        sr_d = word;
      end
      case (state_q)
        SYNC: begin
          if (lr_prev_q && !lrclk_d2_q) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (idx_d == '0 && !lrclk_d2_q) begin
            left_ok_d = 1'b0;
          end
          if (idx_d == IDX_LAST) begin
            if (!lrclk_d2_q) begin
              left_hold_d = word;
              left_ok_d   = 1'b1;
            end else if (left_ok_q) begin
              frame_done = 1'b1;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    // A transfer in the completion cycle frees the slot for the new pair.
    if (frame_done) begin
      if (!valid_q || out_ready) begin
        left_d  = left_hold_q;
        right_d = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata_d1_q  <= 1'b0;
      sdata_d2_q  <= 1'b0;
      bclk_d1_q   <= 1'b0;
      bclk_d2_q   <= 1'b0;
      bclk_d3_q   <= 1'b0;
      lrclk_d1_q  <= 1'b0;
      lrclk_d2_q  <= 1'b0;
      lr_prev_q   <= 1'b0;
      idx_q       <= '0;
      sr_q        <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      state_q     <= SYNC;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sdata_d1_q  <= sdata;
      sdata_d2_q  <= sdata_d1_q;
      bclk_d1_q   <= bclk;
      bclk_d2_q   <= bclk_d1_q;
      bclk_d3_q   <= bclk_d2_q;
      lrclk_d1_q  <= lrclk;
      lrclk_d2_q  <= lrclk_d1_q;
      lr_prev_q   <= lr_prev_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_left  = left_q;
  assign out_right = right_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (overrun_clr) begin
      cnt_d = '0;
    end else if (overrun_d && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign overrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives an I2S generator (bclk period 4 clk) and scoreboards emitted sample pairs.
// Build with I2S_RX_OVERRUN_CNT_EN defined to also exercise overrun_cnt / overrun_clr.
module tb_i2s_rx;
  localparam int DW   = 24;
  localparam int SLOT = 32;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            c;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n, bclk, lrclk, sdata, out_ready;
  logic [DW-1:0] out_left, out_right;
  logic          out_valid, overrun;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic          overrun_clr = 1'b0;
  logic [7:0]    overrun_cnt;
  bit            arm_clr = 1'b0, clr_pending = 1'b0;
`endif

  int    cyc = 0, n_cmp = 0, n_bad = 0, n_ovr = 0, rise_cyc = 0, lsb_cyc = 0;
  logic  valid_prev = 1'b0;
  bit    arm_ready = 1'b0, rdy_pending = 1'b0;
  pair_t exp_q[$];
  pair_t obs_q[$];
  int    obs_rd = 0;

  i2s_rx #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef I2S_RX_OVERRUN_CNT_EN
    .overrun_clr(overrun_clr),
    .overrun_cnt(overrun_cnt),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every transfer, the cycle out_valid rises and overrun pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) obs_q.push_back('{l: out_left, r: out_right, c: cyc});
      if (out_valid && !valid_prev) rise_cyc <= cyc;
      if (overrun) n_ovr <= n_ovr + 1;
    end
    valid_prev <= out_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // One bclk period per bit; lrclk and sdata change while bclk is low.
  task automatic send_slot(input logic w, input logic [DW-1:0] word, input int first_p, input int nbits);
    for (int p = first_p; p < nbits; p++) begin
      @(posedge clk); #1;
      bclk  = 1'b0;
      lrclk = w;
      if (p >= 1 && p <= DW) sdata = word[DW-p];
      else sdata = 1'($urandom_range(1, 0));
      if (rdy_pending) begin
        out_ready   = 1'b1;
        rdy_pending = 1'b0;
      end
`ifdef I2S_RX_OVERRUN_CNT_EN
      if (clr_pending) begin
        overrun_clr = 1'b1;
        clr_pending = 1'b0;
      end
`endif
      @(posedge clk);
`ifdef I2S_RX_OVERRUN_CNT_EN
      #1 overrun_clr = 1'b0;
`endif
      @(posedge clk); #1;
      bclk = 1'b1;
      if (w && p == DW) begin
        lsb_cyc = cyc;
        if (arm_ready) begin
          rdy_pending = 1'b1;
          arm_ready   = 1'b0;
        end
`ifdef I2S_RX_OVERRUN_CNT_EN
        if (arm_clr) begin
          clr_pending = 1'b1;
          arm_clr     = 1'b0;
        end
`endif
      end
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nbits);
    send_slot(1'b0, l, 0, nbits);
    send_slot(1'b1, r, 0, nbits);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++;
    if (out_left !== '0 || out_right !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h want 0/0", out_left, out_right);
    end
`ifdef I2S_RX_OVERRUN_CNT_EN
    n_cmp++;
    if (overrun_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", overrun_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    pair_t e, o;
    obs_rd = obs_q.size(); exp_q.delete();
    send_slot(1'b1, 24'h123456, 0, SLOT);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{l: 24'h800001, r: 24'h7FFFFE, c: 0});
      send_frame(24'h800001, 24'h7FFFFE, SLOT);
      n_cmp++;
      if (rise_cyc - lsb_cyc !== 3) begin
        n_bad++; $display("FAIL basic_latency: got %0d cycles want 3", rise_cyc - lsb_cyc);
      end
    end
    begin
      int n_obs = obs_q.size() - obs_rd;
      n_cmp++;
      if (n_obs != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d pairs want %0d", n_obs, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
        e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
        n_cmp++;
        if (o.l !== e.l || o.r !== e.r) begin n_bad++; $display("FAIL basic_pair: got %h/%h want %h/%h", o.l, o.r, e.l, e.r); end
      end
    end
  endtask

  task automatic test_patterns;
    pair_t e, o;
    logic [DW-1:0] tl[6], tr[6];
    tl = '{24'h000000, 24'hFFFFFF, 24'h800000, 24'hA5A5A5, 24'h000000, 24'h000000};
    tr = '{24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h5A5A5A, 24'h000000, 24'h000000};
    for (int i = 4; i < 6; i++) begin
      tl[i] = 24'($urandom);
      tr[i] = 24'($urandom);
    end
    obs_rd = obs_q.size(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{l: tl[i], r: tr[i], c: 0});
      send_frame(tl[i], tr[i], SLOT);
    end
    begin
      int n_obs = obs_q.size() - obs_rd;
      n_cmp++;
      if (n_obs != exp_q.size()) begin n_bad++; $display("FAIL pattern_count: got %0d pairs want %0d", n_obs, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
        e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
        n_cmp++;
        if (o.l !== e.l || o.r !== e.r) begin n_bad++; $display("FAIL pattern_pair: got %h/%h want %h/%h", o.l, o.r, e.l, e.r); end
      end
    end
  endtask

  task automatic test_reset_mid_right;
    pair_t e, o;
    obs_rd = obs_q.size(); exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b0;
    send_slot(1'b1, 24'hDEADBE, 0, 8);
    @(posedge clk); #1 rst_n = 1'b1;
    send_slot(1'b1, 24'hDEADBE, 8, SLOT);
    exp_q.push_back('{l: 24'h13579B, r: 24'h2468AC, c: 0});
    send_frame(24'h13579B, 24'h2468AC, SLOT);
    exp_q.push_back('{l: 24'hF0F0F0, r: 24'h0F0F0F, c: 0});
    send_frame(24'hF0F0F0, 24'h0F0F0F, SLOT);
    begin
      int n_obs = obs_q.size() - obs_rd;
      n_cmp++;
      if (n_obs != exp_q.size()) begin n_bad++; $display("FAIL rstright_count: got %0d pairs want %0d", n_obs, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
        e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
        n_cmp++;
        if (o.l !== e.l || o.r !== e.r) begin n_bad++; $display("FAIL rstright_pair: got %h/%h want %h/%h", o.l, o.r, e.l, e.r); end
      end
    end
  endtask

  task automatic test_lost_sync;
    pair_t e, o;
    int ovr0;
    obs_rd = obs_q.size(); exp_q.delete();
    ovr0 = n_ovr;
    send_slot(1'b0, 24'h111111, 0, 10);
    send_slot(1'b1, 24'h222222, 0, SLOT);
    send_slot(1'b0, 24'h333333, 0, SLOT);
    send_slot(1'b1, 24'h444444, 0, 10);
    exp_q.push_back('{l: 24'h555555, r: 24'h666666, c: 0});
    send_frame(24'h555555, 24'h666666, SLOT);
    n_cmp++;
    if (n_ovr != ovr0) begin n_bad++; $display("FAIL lost_overrun: got %0d pulses want 0", n_ovr - ovr0); end
    begin
      int n_obs = obs_q.size() - obs_rd;
      n_cmp++;
      if (n_obs != exp_q.size()) begin n_bad++; $display("FAIL lost_count: got %0d pairs want %0d", n_obs, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
        e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
        n_cmp++;
        if (o.l !== e.l || o.r !== e.r) begin n_bad++; $display("FAIL lost_pair: got %h/%h want %h/%h", o.l, o.r, e.l, e.r); end
      end
    end
  endtask

  task automatic test_backpressure;
    pair_t e, o;
    int ovr0;
    obs_rd = obs_q.size(); exp_q.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    exp_q.push_back('{l: 24'hAAAA01, r: 24'hAAAA02, c: 0});
    send_frame(24'hAAAA01, 24'hAAAA02, SLOT);
    n_cmp++;
    if (out_valid !== 1'b1 || out_left !== 24'hAAAA01 || out_right !== 24'hAAAA02) begin
      n_bad++; $display("FAIL bp_hold_a: got v=%b %h/%h want v=1 aaaa01/aaaa02", out_valid, out_left, out_right);
    end
    ovr0 = n_ovr;
    send_frame(24'hBBBB01, 24'hBBBB02, SLOT);
    n_cmp++;
    if (n_ovr - ovr0 != 1) begin n_bad++; $display("FAIL bp_overrun: got %0d pulses want 1", n_ovr - ovr0); end
    n_cmp++;
    if (out_valid !== 1'b1 || out_left !== 24'hAAAA01 || out_right !== 24'hAAAA02) begin
      n_bad++; $display("FAIL bp_still_a: got v=%b %h/%h want v=1 aaaa01/aaaa02", out_valid, out_left, out_right);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got v=%b want 0", out_valid); end
    begin
      int n_obs = obs_q.size() - obs_rd;
      n_cmp++;
      if (n_obs != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d pairs want %0d", n_obs, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
        e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
        n_cmp++;
        if (o.l !== e.l || o.r !== e.r) begin n_bad++; $display("FAIL bp_pair: got %h/%h want %h/%h", o.l, o.r, e.l, e.r); end
      end
    end
  endtask

  task automatic test_back_to_back;
    pair_t e, o;
    int ovr0, r0;
    obs_rd = obs_q.size(); exp_q.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    exp_q.push_back('{l: 24'hC0FFEE, r: 24'hBADC0D, c: 0});
    send_frame(24'hC0FFEE, 24'hBADC0D, SLOT);
    r0   = rise_cyc;
    ovr0 = n_ovr;
    exp_q.push_back('{l: 24'h0C0C0C, r: 24'hF00D42, c: 0});
    arm_ready = 1'b1;
    send_frame(24'h0C0C0C, 24'hF00D42, SLOT);
    n_cmp++;
    if (n_ovr != ovr0) begin n_bad++; $display("FAIL b2b_overrun: got %0d pulses want 0", n_ovr - ovr0); end
    n_cmp++;
    if (rise_cyc != r0) begin n_bad++; $display("FAIL b2b_valid_gap: valid re-rose at %0d, want held since %0d", rise_cyc, r0); end
    n_cmp++;
    if (obs_q.size() - obs_rd < 2 || obs_q[obs_rd+1].c - obs_q[obs_rd].c != 1) begin
      n_bad++; $display("FAIL b2b_adjacent: got %0d pairs, transfers not on consecutive cycles, want 2 adjacent", obs_q.size() - obs_rd);
    end
    begin
      int n_obs = obs_q.size() - obs_rd;
      n_cmp++;
      if (n_obs != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d pairs want %0d", n_obs, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
        e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
        n_cmp++;
        if (o.l !== e.l || o.r !== e.r) begin n_bad++; $display("FAIL b2b_pair: got %h/%h want %h/%h", o.l, o.r, e.l, e.r); end
      end
    end
  endtask

  task automatic test_reset_mid_left;
    pair_t e, o;
    obs_rd = obs_q.size(); exp_q.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    send_frame(24'h777777, 24'h888888, SLOT);
    send_slot(1'b0, 24'h999999, 0, 10);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || overrun !== 1'b0 || out_left !== '0 || out_right !== '0) begin
      n_bad++; $display("FAIL async_reset: got v=%b ovr=%b %h/%h want all 0", out_valid, overrun, out_left, out_right);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send_slot(1'b0, 24'h999999, 10, SLOT);
    send_slot(1'b1, 24'hAAAAAA, 0, SLOT);
    exp_q.push_back('{l: 24'h314159, r: 24'h271828, c: 0});
    send_frame(24'h314159, 24'h271828, SLOT);
    exp_q.push_back('{l: 24'hFEDCBA, r: 24'h012345, c: 0});
    send_frame(24'hFEDCBA, 24'h012345, SLOT);
    begin
      int n_obs = obs_q.size() - obs_rd;
      n_cmp++;
      if (n_obs != exp_q.size()) begin n_bad++; $display("FAIL rstleft_count: got %0d pairs want %0d", n_obs, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
        e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
        n_cmp++;
        if (o.l !== e.l || o.r !== e.r) begin n_bad++; $display("FAIL rstleft_pair: got %h/%h want %h/%h", o.l, o.r, e.l, e.r); end
      end
    end
  endtask

`ifdef I2S_RX_OVERRUN_CNT_EN
  task automatic test_overrun_cnt;
    int ovr0;
    @(posedge clk); #1 out_ready = 1'b0;
    send_frame(24'($urandom), 24'($urandom), DW + 1);
    ovr0 = n_ovr;
    for (int i = 0; i < 300; i++) send_frame(24'($urandom), 24'($urandom), DW + 1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (n_ovr - ovr0 != 300) begin n_bad++; $display("FAIL cnt_pulses: got %0d pulses want 300", n_ovr - ovr0); end
    n_cmp++;
    if (overrun_cnt !== 8'd255) begin n_bad++; $display("FAIL cnt_saturate: got %0d want 255", overrun_cnt); end
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    n_cmp++;
    if (overrun_cnt !== 8'd0) begin n_bad++; $display("FAIL cnt_clear: got %0d want 0", overrun_cnt); end
    send_frame(24'($urandom), 24'($urandom), DW + 1);
    send_frame(24'($urandom), 24'($urandom), DW + 1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (overrun_cnt !== 8'd2) begin n_bad++; $display("FAIL cnt_count2: got %0d want 2", overrun_cnt); end
    arm_clr = 1'b1;
    send_frame(24'($urandom), 24'($urandom), SLOT);
    n_cmp++;
    if (overrun_cnt !== 8'd0) begin n_bad++; $display("FAIL cnt_clear_wins: got %0d want 0", overrun_cnt); end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    obs_rd = obs_q.size();
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_patterns;
    test_reset_mid_right;
    test_lost_sync;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_left;
`ifdef I2S_RX_OVERRUN_CNT_EN
    test_overrun_cnt;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
